// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the IO hub slave port.
// The arbiter uses the slave modport; the environment uses the master modport.
interface io_bus_arbiter_if;
    logic        m0_stb_i, m1_stb_i;
    logic        m0_we_i,  m1_we_i;
    logic [15:0] m0_addr_i, m1_addr_i;
    logic [15:0] m0_dat_i,  m1_dat_i;
    logic        m0_ack_o, m1_ack_o;
    logic        m0_err_o, m1_err_o;
    logic [15:0] m0_dat_o, m1_dat_o;
    logic        s_stb_o, s_we_o;
    logic [15:0] s_addr_o, s_dat_o;
    logic        s_ack_i;
    logic [15:0] s_dat_i;
    logic [1:0]  grant_o;
    logic [7:0]  tmo_cnt_o;

    modport slave (
        input  m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
        input  m0_addr_i, m1_addr_i, m0_dat_i, m1_dat_i,
        input  s_ack_i, s_dat_i,
        output m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
        output s_stb_o, s_we_o, s_addr_o, s_dat_o, grant_o, tmo_cnt_o
    );

    modport master (
        output m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
        output m0_addr_i, m1_addr_i, m0_dat_i, m1_dat_i,
        output s_ack_i, s_dat_i,
        input  m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o, m1_dat_o,
        input  s_stb_o, s_we_o, s_addr_o, s_dat_o, grant_o, tmo_cnt_o
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin two-master arbiter for the IO hub strobe/ack port, one transfer
// per grant, with a per-transfer bus timeout and a saturating timeout counter.
module io_bus_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    io_bus_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] TURN = 2'd2;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             owner;
    logic             last;
    logic [7:0]       wait_cnt;
    logic [7:0]       tmo_cnt;
    logic [1:0]       grant;

    logic [1:0]       stb, we;
    logic [1:0][15:0] addr, wdat;
    logic             busy, own_stb, done, expire;

    assign stb  = {bus.m1_stb_i,  bus.m0_stb_i};
    assign we   = {bus.m1_we_i,   bus.m0_we_i};
    assign addr = {bus.m1_addr_i, bus.m0_addr_i};
    assign wdat = {bus.m1_dat_i,  bus.m0_dat_i};

    assign busy    = (state == BUSY);
    assign own_stb = stb[owner];
    // Ack wins over the timeout when both land in the same cycle.
    assign done    = busy & own_stb & bus.s_ack_i;
    assign expire  = busy & own_stb & ~bus.s_ack_i & (wait_cnt == WAIT_LAST);

    // Slave side follows the owner combinationally so a dropped strobe is seen at once.
    assign bus.s_stb_o  = busy & own_stb;
    assign bus.s_we_o   = busy & we[owner];
    assign bus.s_addr_o = busy ? addr[owner] : '0;
    assign bus.s_dat_o  = busy ? wdat[owner] : '0;

    assign bus.m0_ack_o = done & ~owner;
    assign bus.m1_ack_o = done & owner;
    assign bus.m0_err_o = expire & ~owner;
    assign bus.m1_err_o = expire & owner;
    assign bus.m0_dat_o = bus.m0_ack_o ? bus.s_dat_i : '0;
    assign bus.m1_dat_o = bus.m1_ack_o ? bus.s_dat_i : '0;

    assign bus.grant_o   = grant;
    assign bus.tmo_cnt_o = tmo_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            grant    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (|stb) begin
                        // On a tie the master not served last goes first.
                        owner <= (&stb) ? ~last : stb[1];
                        grant <= (&stb) ? (last ? 2'b01 : 2'b10) : stb;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        last  <= owner;
                        grant <= '0;
                        state <= TURN;
                    end else if (!own_stb) begin
                        grant <= '0;
                        state <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
                        last  <= owner;
                        grant <= '0;
                        state <= TURN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
